uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Buffers 7-bit characters from a producer (test sequencer, keypad scanner, message ROM) in a FIFO.
- Drains the FIFO one character at a time into a uart_tx instance, driving its start/data inputs and pacing itself on its busy output.
- Replaces the hand-timed start counters at the top level, so back-to-back characters reach the serial line without software pacing.

Parameters:
- DATA_W, 7, character width; matches uart_tx data port.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- BUSY_TIMEOUT, 4, cycles to wait after tx_start for tx_busy to rise before declaring the launch lost.

Ports:
- clk  in  1  system clock (50 MHz on board).
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  DATA_W  character to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was dropped.
- launch_err  out  1  sticky; tx_busy never rose within BUSY_TIMEOUT.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  DATA_W  character to uart_tx; stable from tx_start until the transfer ends.
- tx_busy  in  1  uart_tx busy.

Behaviour:
- Single clock domain. All state updates on rising clk.
- Reset, synchronous and active-high, sets:
  - tx_start=0, tx_data=0, count=0, empty=1, full=0, overflow=0, launch_err=0.
  - FSM state = IDLE; read and write pointers = 0.
- Reset mid-transfer flushes the FIFO. The in-flight character is not retried.
- FIFO:
  - Circular, pointers wrap modulo DEPTH.
  - count, full and empty are registered and consistent with the pointers every cycle.
- Write rules:
  - wr_en with full=0 stores wr_data at the write pointer, advances the pointer and increments count.
  - wr_en with full=1 drops the data and sets overflow. This holds even if a pop happens in the same cycle.
- Pop and write in the same cycle with full=0: both take effect and count is unchanged.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If empty=0 and tx_busy=0: at the next edge, load tx_data from the FIFO head, drive tx_start=1 for exactly one cycle, advance the read pointer, decrement count, and go to WAIT_BUSY.
  - Otherwise stay in IDLE.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE and clear the timeout counter.
  - tx_busy=0: increment the timeout counter.
  - Counter reaches BUSY_TIMEOUT: set launch_err and return to IDLE. The character is discarded.
- WAIT_DONE: on tx_busy=0, return to IDLE.
- tx_data holds its value from the launch edge until the FSM re-enters IDLE.
- Latency: wr_en sampled at edge E0 into an empty FIFO, with the FSM in IDLE and tx_busy=0:
  - empty falls at E0.
  - tx_start is high between E1 and E2.
- Spacing: at least one IDLE cycle between the falling edge of tx_busy and the next tx_start.
- overflow and launch_err clear only on rst.
- tx_start is never asserted while tx_busy=1 or while empty=1 at the IDLE decision.

Test Plan:
- Reset, then one write of 7'h41 → tx_start high exactly one cycle, 2 edges after the write edge, with tx_data=7'h41; count returns to 0.
- Write 7'h41, 7'h42, 7'h43 back-to-back with a uart_tx model (busy for 100 cycles) → three single-cycle start pulses, each after busy falls plus 1 idle cycle, data in order 41, 42, 43; the uart_rx loopback produces the same sequence.
- Write DEPTH+2 characters with tx_busy forced high → full=1 after 16 writes, count=16; the last 2 are dropped and overflow=1; releasing busy drains exactly 16 characters in order.
- Hold tx_busy=0 permanently after a launch → launch_err=1 BUSY_TIMEOUT cycles after tx_start, FSM back in IDLE; the next queued character still launches.
- Simultaneous wr_en and pop with count=5 → count stays 5, data order preserved across the pointer wrap after 20 total characters.
- Assert rst during WAIT_DONE with 3 characters queued → next cycle count=0, empty=1, tx_start=0, flags cleared; no further start pulses.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Buffers characters from a producer in a circular FIFO and hands them one
//   at a time to a uart_tx instance. The FSM drives a one-cycle tx_start and
//   a tx_data value that stays stable for the whole transfer. It paces itself
//   on tx_busy, so back-to-back characters need no software timing.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset (flushes FIFO, clears flags)
//   wr_en       push wr_data this cycle
//   wr_data     character to enqueue
//   full        FIFO holds DEPTH entries (registered)
//   empty       FIFO holds 0 entries (registered)
//   count       occupancy 0..DEPTH (registered)
//   overflow    sticky: a write arrived while full and was dropped
//   launch_err  sticky: tx_busy did not rise within BUSY_TIMEOUT cycles of a launch
//   tx_start    one-cycle start pulse to uart_tx
//   tx_data     character presented to uart_tx
//   tx_busy     uart_tx busy
module uart_tx_feeder #(
  parameter int DATA_W       = 7,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              launch_err,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_ZERO   = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;

  // Launch FSM state
  state_e            state_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              launch_err_q;

  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign launch_err = launch_err_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;

  assign head_s = mem_q[rd_ptr_q];

  // FIFO next-state: push/pop qualification, pointer advance and occupancy
  always_comb begin
    // A write while full is dropped even if the same edge pops an entry.
    push_s = wr_en & ~full_q;
    // The pop is the IDLE launch decision itself, made on registered empty.
    pop_s  = (state_q == IDLE) & ~empty_q & ~tx_busy;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == CNT_ZERO);

    if (wr_en & full_q) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO pointer, occupancy and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Launch FSM with registered tx_start/tx_data/launch_err
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      to_cnt_q     <= TO_ZERO;
      tx_start_q   <= 1'b0;
      tx_data_q    <= DATA_ZERO;
      launch_err_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            tx_data_q  <= head_s;
            tx_start_q <= 1'b1;
            to_cnt_q   <= TO_ZERO;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            to_cnt_q <= TO_ZERO;
            state_q  <= WAIT_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            // The BUSY_TIMEOUT-th quiet cycle: the launch is lost, drop it.
            to_cnt_q     <= TO_ZERO;
            launch_err_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        WAIT_DONE: begin
          // Returning to IDLE here guarantees one IDLE cycle before the next start.
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DW    = 7;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BT    = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          launch_err;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;

  uart_tx_feeder #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .launch_err(launch_err), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          wr;
    logic [DW-1:0] data;
    int            bm;
    int            cnt;
    logic          emp;
    logic          ful;
    logic          st;
    logic          ovf;
    logic [DW-1:0] xd;
  } vec_t;

  vec_t tbl [21];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: the FIFO content as a plain queue plus sticky flags.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] launched [$];
  logic          exp_ovf;
  logic          exp_err;
  logic          prev_start;
  logic [DW-1:0] last_data;
  int            low_run;
  int            nstart;
  // uart_tx stand-in: 0 = responds to start, 1 = forced busy, 2 = forced idle
  int            bmode;
  int            busy_cnt;
  int            busy_len;
  bit            rand_len;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: sample pre-edge inputs, advance, check against the model, update uart stand-in.
  task automatic step();
    logic          pre_start, pre_busy, pre_wr, pre_rst;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] e;
    int            pre_size;
    pre_start = tx_start;
    pre_busy  = tx_busy;
    pre_wr    = wr_en;
    pre_rst   = rst;
    pre_data  = wr_data;
    pre_size  = model_q.size();
    @(posedge clk);
    #1;
    cyc++;
    low_run++;
    if (pre_rst) begin
      model_q.delete();
      exp_ovf   = 1'b0;
      exp_err   = 1'b0;
      last_data = '0;
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
    end else begin
      if (pre_wr) begin
        if (pre_size >= DEPTH) exp_ovf = 1'b1;
        else model_q.push_back(pre_data);
      end
      if (tx_start) begin
        nstart++;
        launched.push_back(tx_data);
        chk("start_legal", int'(pre_size == 0 || pre_busy), 0);
        chk("start_spacing", int'(low_run >= 2), 1);
        chk("start_width", int'(prev_start), 0);
        if (model_q.size() > 0) begin
          e = model_q.pop_front();
          chk("tx_data_order", int'(tx_data), int'(e));
        end
        last_data = tx_data;
      end else if (pre_busy) begin
        chk("tx_data_hold", int'(tx_data), int'(last_data));
      end
    end
    chk("count", int'(count), model_q.size());
    chk("empty", int'(empty), int'(model_q.size() == 0));
    chk("full", int'(full), int'(model_q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("launch_err", int'(launch_err), int'(exp_err));
    prev_start = tx_start;
    case (bmode)
      0: begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            tx_busy = 1'b0;
            low_run = 0;
          end
        end else if (pre_start) begin
          tx_busy  = 1'b1;
          busy_cnt = rand_len ? int'($urandom_range(1, 8)) : busy_len;
        end
      end
      1: begin
        tx_busy  = 1'b1;
        busy_cnt = 0;
      end
      default: begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
      end
    endcase
  endtask

  task automatic run_vec(input int i);
    wr_en   = tbl[i].wr;
    wr_data = tbl[i].data;
    bmode   = tbl[i].bm;
    step();
    chk("vec_count", int'(count), tbl[i].cnt);
    chk("vec_empty", int'(empty), int'(tbl[i].emp));
    chk("vec_full", int'(full), int'(tbl[i].ful));
    chk("vec_tx_start", int'(tx_start), int'(tbl[i].st));
    chk("vec_overflow", int'(overflow), int'(tbl[i].ovf));
    if (tbl[i].st) chk("vec_tx_data", int'(tx_data), int'(tbl[i].xd));
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (!(model_q.size() == 0 && !tx_busy && !tx_start && busy_cnt == 0) && n < max) begin
      step();
      n++;
    end
    chk("idle_wait_bound", int'(n < max), 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    int n0;
    // Single write: launch 2 edges after the write edge, then idle again.
    tbl[0] = '{1'b1, 7'h41, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
    tbl[1] = '{1'b0, 7'h00, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h41};
    tbl[2] = '{1'b0, 7'h00, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
    // DEPTH+2 writes with uart busy: fills at 16, last two dropped.
    for (int k = 1; k <= 18; k++) begin
      tbl[2+k] = '{1'b1, 7'(16 + k - 1), 1, (k > 16) ? 16 : k,
                   1'b0, (k >= 16), 1'b0, (k > 16), 7'h00};
    end

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_busy = 1'b0;
    exp_ovf = 1'b0; exp_err = 1'b0; prev_start = 1'b0; last_data = '0;
    low_run = 100; nstart = 0; bmode = 0; busy_cnt = 0; busy_len = 100; rand_len = 1'b0;
    step();
    do_reset();

    // 1. single character latency
    for (int i = 0; i < 3; i++) run_vec(i);
    wr_en = 1'b0;
    wait_idle(200);

    // 2. back-to-back characters with a 100-cycle uart
    launched.delete();
    put(7'h41); put(7'h42); put(7'h43);
    wait_idle(400);
    chk("b2b_n", launched.size(), 3);
    for (int i = 0; i < 3 && i < launched.size(); i++) chk("b2b_order", int'(launched[i]), 'h41 + i);

    // 3. randomized traffic with random transfer lengths
    do_reset();
    rand_len = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 7'($urandom);
      step();
    end
    wr_en = 1'b0;
    wait_idle(300);
    rand_len = 1'b0;

    // 4. simultaneous push and pop at count 5, then wrap past 20 characters
    do_reset();
    bmode = 1; tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) put(7'(8'h60 + i));
    chk("sim_pre_count", int'(count), 5);
    bmode = 0; tx_busy = 1'b0; busy_cnt = 0; busy_len = 6;
    launched.delete();
    wr_en = 1'b1; wr_data = 7'h65;
    step();
    wr_en = 1'b0;
    chk("sim_pop", int'(tx_start), 1);
    chk("sim_count", int'(count), 5);
    for (int j = 6; j < 20; j++) begin
      put(7'(8'h60 + j));
      repeat (4) step();
    end
    wait_idle(400);
    chk("wrap_n", launched.size(), 20);
    for (int i = 0; i < 20 && i < launched.size(); i++) chk("wrap_order", int'(launched[i]), 'h60 + i);

    // 5. lost launch: busy never rises
    bmode = 2; tx_busy = 1'b0;
    put(7'h55);
    put(7'h2A);
    chk("to_launch", int'(tx_start), 1);
    for (int i = 0; i < BT - 1; i++) begin
      step();
      chk("to_err_early", int'(launch_err), 0);
    end
    exp_err = 1'b1;
    step();
    chk("to_err_set", int'(launch_err), 1);
    step();
    chk("to_relaunch", int'(tx_start), 1);
    chk("to_relaunch_data", int'(tx_data), 'h2A);
    repeat (8) step();

    // 6. fill with busy held, overflow, then drain 16 in order
    bmode = 1; tx_busy = 1'b1;
    for (int i = 3; i < 21; i++) run_vec(i);
    wr_en = 1'b0;
    bmode = 0; tx_busy = 1'b0; busy_cnt = 0; busy_len = 100;
    launched.delete();
    wait_idle(16 * 110 + 100);
    chk("drain_n", launched.size(), 16);
    for (int i = 0; i < 16 && i < launched.size(); i++) chk("drain_order", int'(launched[i]), 16 + i);

    // 7. reset during WAIT_DONE with 3 characters queued
    put(7'h31); put(7'h32); put(7'h33); put(7'h34);
    repeat (6) step();
    chk("pre_rst_count", int'(count), 3);
    chk("pre_rst_ovf", int'(overflow), 1);
    chk("pre_rst_err", int'(launch_err), 1);
    do_reset();
    chk("post_rst_count", int'(count), 0);
    chk("post_rst_empty", int'(empty), 1);
    chk("post_rst_start", int'(tx_start), 0);
    chk("post_rst_ovf", int'(overflow), 0);
    chk("post_rst_err", int'(launch_err), 0);
    n0 = nstart;
    repeat (300) step();
    chk("no_start_after_rst", nstart - n0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
